reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_seq_pkg.sv | 13 +
 rtl/sync_bit.sv | 20 ++
 rtl/reset_sequencer.sv | 175 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared encodings for the reset sequencer: FSM state values and loss-counter width.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      ST_HOLD      = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_RELEASE   = 2'd2,
      ST_RUN       = 2'd3
   } seq_state_e;

   localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/sync_bit.sv
// Single-bit flop-chain synchroniser; all stages clear to 0 on reset.
module sync_bit #(
   parameter int STAGES = 3
) (
   input  logic clk_input,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk_input or negedge rst_n) begin
      if (!rst_n) chain <= '0;
      else        chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: waits for stable PLL lock, then releases domain resets in order.
//
// state      | meaning
// HOLD       | all domain resets asserted, minimum hold time running
// WAIT_LOCK  | hold done, waiting for LOCK_STABLE good cycles
// RELEASE    | domains released one every GAP_CYCLES
// RUN        | all domains out of reset
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_LOCKS   = 2,
   parameter int NUM_DOMAINS = 5,
   parameter int SYNC_STAGES = 3,
   parameter int LOCK_STABLE = 1024,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 64,
   parameter int LONG_PRESS  = 500000
) (
   input  logic                   clk_input,
   input  logic                   rst_n_input,
   input  logic [NUM_LOCKS-1:0]   pll_locked,
   input  logic [NUM_LOCKS-1:0]   lock_mask,
   input  logic                   ext_rst_n,
   input  logic                   sw_rst_req,
   input  logic                   lock_lost_clr,
   output logic [NUM_DOMAINS-1:0] rst_n_out,
   output logic                   all_released,
   output logic [1:0]             seq_state,
   output logic                   lock_lost,
   output logic [LOSS_CNT_W-1:0]  lock_loss_cnt
);

   localparam int STABLE_W = $clog2(LOCK_STABLE + 1);
   localparam int PRESS_W  = $clog2(LONG_PRESS + 1);
   localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);
   localparam int GAP_W    = $clog2(GAP_CYCLES + 1);

   localparam logic [STABLE_W-1:0]   STABLE_MAX = STABLE_W'(LOCK_STABLE);
   localparam logic [PRESS_W-1:0]    PRESS_MAX  = PRESS_W'(LONG_PRESS);
   localparam logic [HOLD_W-1:0]     HOLD_MAX   = HOLD_W'(HOLD_CYCLES);
   localparam logic [GAP_W-1:0]      GAP_MAX    = GAP_W'(GAP_CYCLES);
   localparam logic [LOSS_CNT_W-1:0] LOSS_MAX   = '1;

   logic                   rst_n_sync;
   logic [NUM_LOCKS-1:0]   pll_sync;
   logic                   ext_sync;
   logic                   locks_ok;
   logic                   lock_stable;
   logic                   press_evt;
   logic                   abort;
   logic                   loss_evt;
   logic [STABLE_W-1:0]    stable_cnt;
   logic [PRESS_W-1:0]     press_cnt;
   logic [HOLD_W-1:0]      hold_cnt;
   logic [GAP_W-1:0]       gap_cnt, gap_d;
   logic [NUM_DOMAINS-1:0] rst_q, rst_d;
   seq_state_e             state_q, state_d;

   sync_bit #(.STAGES(2)) u_rst_sync (
      .clk_input(clk_input), .rst_n(rst_n_input), .d(1'b1), .q(rst_n_sync)
   );

   for (genvar i = 0; i < NUM_LOCKS; i++) begin : g_pll_sync
      sync_bit #(.STAGES(SYNC_STAGES)) u_pll_sync (
         .clk_input(clk_input), .rst_n(rst_n_sync), .d(pll_locked[i]), .q(pll_sync[i])
      );
   end

   sync_bit #(.STAGES(SYNC_STAGES)) u_ext_sync (
      .clk_input(clk_input), .rst_n(rst_n_sync), .d(ext_rst_n), .q(ext_sync)
   );

   assign locks_ok    = &(pll_sync | lock_mask);
   assign lock_stable = (stable_cnt == STABLE_MAX);
   // Fires on the cycle the press count steps onto its limit, so it pulses exactly once per press.
   assign press_evt   = !ext_sync && (press_cnt == PRESS_MAX - 1'b1);
   assign abort       = sw_rst_req || press_evt || !locks_ok;
   assign loss_evt    = (state_q == ST_RUN) && !locks_ok;

   always_ff @(posedge clk_input or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         stable_cnt <= '0;
         press_cnt  <= '0;
         hold_cnt   <= '0;
      end else begin
         if (!locks_ok)                  stable_cnt <= '0;
         else if (stable_cnt != STABLE_MAX) stable_cnt <= stable_cnt + 1'b1;

         if (ext_sync)                   press_cnt <= '0;
         else if (press_cnt != PRESS_MAX) press_cnt <= press_cnt + 1'b1;

         if (state_q != ST_HOLD)         hold_cnt <= '0;
         else if (hold_cnt != HOLD_MAX)  hold_cnt <= hold_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_input or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         state_q <= ST_HOLD;
         rst_q   <= '0;
         gap_cnt <= '0;
      end else begin
         state_q <= state_d;
         rst_q   <= rst_d;
         gap_cnt <= gap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rst_d   = rst_q;
      gap_d   = gap_cnt;
      case (state_q)
         ST_HOLD: begin
            rst_d = '0;
            gap_d = '0;
            if (hold_cnt == HOLD_MAX && press_cnt < PRESS_MAX) state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (abort) begin
               state_d = ST_HOLD;
               rst_d   = '0;
            end else if (lock_stable) begin
               rst_d   = NUM_DOMAINS'(1);
               gap_d   = GAP_MAX;
               state_d = (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (abort) begin
               state_d = ST_HOLD;
               rst_d   = '0;
               gap_d   = '0;
            end else if (gap_cnt == GAP_W'(1)) begin
               // Thermometer shift releases the next domain; RUN coincides with the last one.
               rst_d = (rst_q << 1) | NUM_DOMAINS'(1);
               gap_d = GAP_MAX;
               if (rst_d[NUM_DOMAINS-1]) state_d = ST_RUN;
            end else begin
               gap_d = gap_cnt - 1'b1;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_HOLD;
               rst_d   = '0;
            end
         end
         default: begin
            state_d = ST_HOLD;
            rst_d   = '0;
         end
      endcase
   end

   // A loss coinciding with a clear wins, leaving a count of one.
   always_ff @(posedge clk_input or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         lock_lost     <= 1'b0;
         lock_loss_cnt <= '0;
      end else if (loss_evt) begin
         lock_lost <= 1'b1;
         if (lock_lost_clr)                lock_loss_cnt <= LOSS_CNT_W'(1);
         else if (lock_loss_cnt != LOSS_MAX) lock_loss_cnt <= lock_loss_cnt + 1'b1;
      end else if (lock_lost_clr) begin
         lock_lost     <= 1'b0;
         lock_loss_cnt <= '0;
      end
   end

   assign rst_n_out    = rst_q;
   assign all_released = (state_q == ST_RUN);
   assign seq_state    = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with small timing parameters and hand-computed cycle counts.
module tb_reset_sequencer;

   logic       clk_input = 1'b0;
   logic       rst_n_input;
   logic [1:0] pll_locked;
   logic [1:0] lock_mask;
   logic       ext_rst_n;
   logic       sw_rst_req;
   logic       lock_lost_clr;
   logic [2:0] rst_n_out;
   logic       all_released;
   logic [1:0] seq_state;
   logic       lock_lost;
   logic [7:0] lock_loss_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk_input = ~clk_input;

   reset_sequencer #(
      .NUM_LOCKS(2), .NUM_DOMAINS(3), .SYNC_STAGES(3), .LOCK_STABLE(8),
      .HOLD_CYCLES(4), .GAP_CYCLES(3), .LONG_PRESS(10)
   ) dut (
      .clk_input(clk_input), .rst_n_input(rst_n_input), .pll_locked(pll_locked),
      .lock_mask(lock_mask), .ext_rst_n(ext_rst_n), .sw_rst_req(sw_rst_req),
      .lock_lost_clr(lock_lost_clr), .rst_n_out(rst_n_out), .all_released(all_released),
      .seq_state(seq_state), .lock_lost(lock_lost), .lock_loss_cnt(lock_loss_cnt)
   );

   task automatic step(input int n);
      repeat (n) @(negedge clk_input);
   endtask

   // Leaves the bench on the negedge where rst_n_input is released.
   task automatic do_reset(input logic [1:0] locks, input logic [1:0] mask);
      @(negedge clk_input);
      rst_n_input = 1'b0; pll_locked = locks; lock_mask = mask;
      ext_rst_n = 1'b1; sw_rst_req = 1'b0; lock_lost_clr = 1'b0;
      step(3);
      rst_n_input = 1'b1;
   endtask

   task automatic wait_out0(input int max, output int n, output bit ok);
      n = 0; ok = 1'b0;
      while (n < max && !ok) begin
         step(1); n++;
         if (rst_n_out[0]) ok = 1'b1;
      end
   endtask

   task automatic wait_run(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         step(1);
         if (all_released) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      step(3);
      checks++; if (seq_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", seq_state); end
      checks++; if (rst_n_out !== 3'b000) begin errors++; $display("FAIL reset_out got %b want 000", rst_n_out); end
      checks++; if (all_released !== 1'b0) begin errors++; $display("FAIL reset_all_rel got %b want 0", all_released); end
      checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL reset_lock_lost got %b want 0", lock_lost); end
      checks++; if (lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", lock_loss_cnt); end
   endtask

   task automatic test_release();
      int n; bit ok;
      do_reset(2'b11, 2'b00);
      wait_out0(40, n, ok);
      checks++; if (!ok || n != 14) begin errors++; $display("FAIL release_latency got %0d (ok=%0b) want 14", n, ok); end
      checks++; if (rst_n_out !== 3'b001 || seq_state !== 2'd2) begin errors++; $display("FAIL release_d0 got out=%b st=%0d want 001/2", rst_n_out, seq_state); end
      step(2);
      checks++; if (rst_n_out !== 3'b001) begin errors++; $display("FAIL release_gap1_early got %b want 001", rst_n_out); end
      step(1);
      checks++; if (rst_n_out !== 3'b011 || seq_state !== 2'd2) begin errors++; $display("FAIL release_d1 got out=%b st=%0d want 011/2", rst_n_out, seq_state); end
      step(2);
      checks++; if (rst_n_out !== 3'b011 || all_released !== 1'b0) begin errors++; $display("FAIL release_gap2_early got out=%b all=%b want 011/0", rst_n_out, all_released); end
      step(1);
      checks++; if (rst_n_out !== 3'b111 || all_released !== 1'b1 || seq_state !== 2'd3) begin
         errors++; $display("FAIL release_d2 got out=%b all=%b st=%0d want 111/1/3", rst_n_out, all_released, seq_state); end
   endtask

   task automatic test_lock_loss();
      int n; bit ok;
      pll_locked = 2'b01; step(1); pll_locked = 2'b11;
      step(2);
      checks++; if (rst_n_out !== 3'b111) begin errors++; $display("FAIL loss_sync_delay got %b want 111", rst_n_out); end
      step(1);
      checks++; if (rst_n_out !== 3'b000 || seq_state !== 2'd0) begin errors++; $display("FAIL loss_hold got out=%b st=%0d want 000/0", rst_n_out, seq_state); end
      checks++; if (lock_lost !== 1'b1 || lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL loss_flag got lost=%b cnt=%0d want 1/1", lock_lost, lock_loss_cnt); end
      wait_out0(40, n, ok);
      checks++; if (!ok || n != 9) begin errors++; $display("FAIL loss_rerelease got %0d (ok=%0b) want 9", n, ok); end
      wait_run(20, ok);
      checks++; if (!ok || lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL loss_rerun got ok=%0b cnt=%0d want 1/1", ok, lock_loss_cnt); end
   endtask

   task automatic test_second_loss();
      bit ok;
      pll_locked = 2'b10; step(1); pll_locked = 2'b11;
      step(3);
      checks++; if (lock_loss_cnt !== 8'd2 || lock_lost !== 1'b1) begin errors++; $display("FAIL second_loss got cnt=%0d lost=%b want 2/1", lock_loss_cnt, lock_lost); end
      wait_run(40, ok);
      checks++; if (!ok) begin errors++; $display("FAIL second_loss_rerun got timeout want run"); end
   endtask

   task automatic test_clr_race();
      bit ok;
      pll_locked = 2'b10; step(1); pll_locked = 2'b11;
      step(2);
      lock_lost_clr = 1'b1; step(1); lock_lost_clr = 1'b0;
      checks++; if (lock_lost !== 1'b1 || lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL clr_race got lost=%b cnt=%0d want 1/1", lock_lost, lock_loss_cnt); end
      checks++; if (seq_state !== 2'd0) begin errors++; $display("FAIL clr_race_state got %0d want 0", seq_state); end
      wait_run(40, ok);
      lock_lost_clr = 1'b1; step(1); lock_lost_clr = 1'b0;
      checks++; if (!ok || lock_lost !== 1'b0 || lock_loss_cnt !== 8'd0) begin
         errors++; $display("FAIL clr_alone got ok=%0b lost=%b cnt=%0d want 1/0/0", ok, lock_lost, lock_loss_cnt); end
      pll_locked = 2'b01; step(1); pll_locked = 2'b11;
      step(3);
      checks++; if (lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL loss_after_clr got %0d want 1", lock_loss_cnt); end
      wait_run(40, ok);
   endtask

   task automatic test_async_reset();
      @(negedge clk_input);
      #2 rst_n_input = 1'b0;
      #1;
      checks++; if (rst_n_out !== 3'b000 || all_released !== 1'b0 || seq_state !== 2'd0) begin
         errors++; $display("FAIL async_rst got out=%b all=%b st=%0d want 000/0/0", rst_n_out, all_released, seq_state); end
      checks++; if (lock_lost !== 1'b0 || lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL async_rst_loss got lost=%b cnt=%0d want 0/0", lock_lost, lock_loss_cnt); end
   endtask

   task automatic test_wait_glitch();
      do_reset(2'b11, 2'b00);
      step(8);
      pll_locked = 2'b10; step(1); pll_locked = 2'b11;
      step(2);
      checks++; if (seq_state !== 2'd1) begin errors++; $display("FAIL glitch_pre got st=%0d want 1", seq_state); end
      step(1);
      checks++; if (seq_state !== 2'd0 || rst_n_out !== 3'b000) begin errors++; $display("FAIL glitch_hold got st=%0d out=%b want 0/000", seq_state, rst_n_out); end
      step(2);
      checks++; if (rst_n_out !== 3'b000) begin errors++; $display("FAIL glitch_no_early got %b want 000", rst_n_out); end
      step(6);
      checks++; if (rst_n_out !== 3'b000 || seq_state !== 2'd1) begin errors++; $display("FAIL glitch_last_wait got out=%b st=%0d want 000/1", rst_n_out, seq_state); end
      step(1);
      checks++; if (rst_n_out !== 3'b001 || seq_state !== 2'd2) begin errors++; $display("FAIL glitch_release got out=%b st=%0d want 001/2", rst_n_out, seq_state); end
      checks++; if (lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL glitch_cnt got %0d want 0", lock_loss_cnt); end
   endtask

   task automatic test_ext_press();
      bit ok; int bad; int entries; logic [1:0] prev;
      do_reset(2'b11, 2'b00);
      wait_run(40, ok);
      checks++; if (!ok) begin errors++; $display("FAIL press_setup got timeout want run"); end
      ext_rst_n = 1'b0; step(9); ext_rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         step(1);
         if (seq_state != 2'd3) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL press_short got %0d non-run cycles want 0", bad); end
      ext_rst_n = 1'b0;
      entries = 0; prev = seq_state;
      for (int i = 1; i <= 34; i++) begin
         step(1);
         if (i == 20) ext_rst_n = 1'b1;
         if (prev != 2'd0 && seq_state == 2'd0) entries++;
         prev = seq_state;
         if (i == 12) begin checks++; if (seq_state !== 2'd3) begin errors++; $display("FAIL press_before got st=%0d want 3", seq_state); end end
         if (i == 13) begin checks++; if (seq_state !== 2'd0 || rst_n_out !== 3'b000) begin errors++; $display("FAIL press_evt got st=%0d out=%b want 0/000", seq_state, rst_n_out); end end
         if (i == 24) begin checks++; if (seq_state !== 2'd0) begin errors++; $display("FAIL press_held got st=%0d want 0", seq_state); end end
         if (i == 25) begin checks++; if (seq_state !== 2'd1) begin errors++; $display("FAIL press_exit got st=%0d want 1", seq_state); end end
      end
      checks++; if (entries != 1) begin errors++; $display("FAIL press_entries got %0d want 1", entries); end
      checks++; if (all_released !== 1'b1 || lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL press_after got all=%b cnt=%0d want 1/0", all_released, lock_loss_cnt); end
   endtask

   task automatic test_mask_sw();
      int n; bit ok;
      do_reset(2'b01, 2'b10);
      wait_out0(40, n, ok);
      checks++; if (!ok || n != 14) begin errors++; $display("FAIL mask_latency got %0d (ok=%0b) want 14", n, ok); end
      wait_run(20, ok);
      checks++; if (!ok || rst_n_out !== 3'b111) begin errors++; $display("FAIL mask_run got ok=%0b out=%b want 1/111", ok, rst_n_out); end
      sw_rst_req = 1'b1; step(1); sw_rst_req = 1'b0;
      checks++; if (rst_n_out !== 3'b000 || seq_state !== 2'd0) begin errors++; $display("FAIL sw_run got out=%b st=%0d want 000/0", rst_n_out, seq_state); end
      wait_out0(40, n, ok);
      checks++; if (!ok || seq_state !== 2'd2) begin errors++; $display("FAIL sw_rerelease got ok=%0b st=%0d want 1/2", ok, seq_state); end
      sw_rst_req = 1'b1; step(1); sw_rst_req = 1'b0;
      checks++; if (rst_n_out !== 3'b000 || seq_state !== 2'd0) begin errors++; $display("FAIL sw_release got out=%b st=%0d want 000/0", rst_n_out, seq_state); end
      checks++; if (lock_loss_cnt !== 8'd0 || lock_lost !== 1'b0) begin errors++; $display("FAIL sw_cnt got cnt=%0d lost=%b want 0/0", lock_loss_cnt, lock_lost); end
   endtask

   initial begin
      rst_n_input = 1'b0; pll_locked = 2'b11; lock_mask = 2'b00;
      ext_rst_n = 1'b1; sw_rst_req = 1'b0; lock_lost_clr = 1'b0;
      test_reset();
      test_release();
      test_lock_loss();
      test_second_loss();
      test_clr_race();
      test_async_reset();
      test_wait_glitch();
      test_ext_press();
      test_mask_sw();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
